// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one external combinational unsigned divider among NUM_REQ requesters.
//
// A round-robin arbiter grants one requester at a time. The granted operands are registered
// onto div_a/div_b and held for DIV_LATENCY cycles (a multicycle path through the divider),
// after which the quotient is captured and returned to the owner over a valid/ready channel.
//
// Optional feature: define DIV_SHARE_ZERO_SAT_EN to short-circuit zero divisors. The accept
// then goes straight to the response with an all-ones quotient and div_by_zero set. Without
// the macro a zero divisor takes the normal path and div_by_zero is tied low.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ]           per-requester request valid
//   req_ready   out  [NUM_REQ]           per-requester accept, at most one bit high
//   req_a       in   [NUM_REQ*BITWIDTH]  packed dividends, slice i at [i*BITWIDTH +: BITWIDTH]
//   req_b       in   [NUM_REQ*BITWIDTH]  packed divisors, same packing
//   rsp_valid   out  [NUM_REQ]           one-hot response valid to the owner
//   rsp_ready   in   [NUM_REQ]           per-requester response accept
//   rsp_result  out  [BITWIDTH]          quotient, qualified by rsp_valid
//   div_a       out  [BITWIDTH]          registered dividend to the divider
//   div_b       out  [BITWIDTH]          registered divisor to the divider
//   div_result  in   [BITWIDTH]          combinational quotient from the divider
//   busy        out                      high whenever not idle
//   div_by_zero out                      zero-divisor flag, valid with rsp_valid
module div_share_ctrl #(
    parameter int unsigned BITWIDTH    = 16,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DIV_LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_a,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [BITWIDTH-1:0]          rsp_result,
    output logic [BITWIDTH-1:0]          div_a,
    output logic [BITWIDTH-1:0]          div_b,
    input  logic [BITWIDTH-1:0]          div_result,
    output logic                         busy,
    output logic                         div_by_zero
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

    if (NUM_REQ < 2) begin : gen_num_req_check
        $error("div_share_ctrl: NUM_REQ must be at least 2");
    end
    if (DIV_LATENCY < 1) begin : gen_latency_check
        $error("div_share_ctrl: DIV_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BITWIDTH-1:0] div_a_q, div_a_d;
    logic [BITWIDTH-1:0] div_b_q, div_b_d;
    logic [BITWIDTH-1:0] result_q, result_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
`ifdef DIV_SHARE_ZERO_SAT_EN
    logic                dbz_q, dbz_d;
`endif

    // Round-robin search: first valid requester at or after the pointer.
    logic                grant_found;
    logic [IdxW-1:0]     grant_idx;
    int unsigned         cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(rr_q) + off) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    logic [BITWIDTH-1:0] sel_a, sel_b;
    assign sel_a = req_a[grant_idx*BITWIDTH +: BITWIDTH];
    assign sel_b = req_b[grant_idx*BITWIDTH +: BITWIDTH];

    logic accept;
    assign accept = (state_q == StIdle) && grant_found;

    // Gated by rst_n so no accept is advertised while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        result_d    = result_q;
        rsp_valid_d = rsp_valid_q;
`ifdef DIV_SHARE_ZERO_SAT_EN
        dbz_d       = dbz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    div_a_d = sel_a;
                    div_b_d = sel_b;
                    owner_d = grant_idx;
                    rr_d    = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d   = CntW'(DIV_LATENCY - 1);
                    state_d = StWait;
`ifdef DIV_SHARE_ZERO_SAT_EN
                    if (sel_b == '0) begin
                        result_d               = '1;
                        dbz_d                  = 1'b1;
                        rsp_valid_d            = '0;
                        rsp_valid_d[grant_idx] = 1'b1;
                        state_d                = StResp;
                    end
`endif
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d             = div_result;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = StResp;
                end
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
`ifdef DIV_SHARE_ZERO_SAT_EN
                    dbz_d       = 1'b0;
`endif
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            result_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            result_q    <= result_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

`ifdef DIV_SHARE_ZERO_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with BITWIDTH=16, NUM_REQ=4, DIV_LATENCY=4.
// A behavioural divider stands in for the external combinational divider.
module tb_div_share_ctrl;

    localparam int unsigned BW = 16;
    localparam int unsigned NR = 4;
    localparam int unsigned DL = 4;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*BW-1:0]  req_a;
    logic [NR*BW-1:0]  req_b;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [BW-1:0]     rsp_result;
    logic [BW-1:0]     div_a;
    logic [BW-1:0]     div_b;
    logic [BW-1:0]     div_result;
    logic              busy;
    logic              div_by_zero;

    int checks   = 0;
    int failures = 0;

    div_share_ctrl #(
        .BITWIDTH    (BW),
        .NUM_REQ     (NR),
        .DIV_LATENCY (DL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_result  (div_result),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    // Divider stand-in; a zero divisor returns all ones.
    assign div_result = (div_b == '0) ? '1 : div_a / div_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
        req_a[i*BW +: BW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    // Full transaction with rsp_ready already high for the owner.
    task automatic run_txn(input string tag, input logic [NR-1:0] grant, input logic [BW-1:0] q);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(grant));
        step();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (DL - 1) step();
        check({tag, "_early"}, 32'(rsp_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(rsp_valid), 32'(grant));
        check({tag, "_result"}, 32'(rsp_result), 32'(q));
        step();
        check({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '0;
        repeat (2) step();
        req_valid = 4'b0001;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_div_a", 32'(div_a), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        // Requester 2: 100/7
        set_op(2, 16'd100, 16'd7);
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        check("t1_div_a", 32'(div_a), 32'd100);
        check("t1_div_b", 32'(div_b), 32'd7);
        check("t1_ready_wait", 32'(req_ready), 32'd0);
        repeat (DL - 1) step();
        check("t1_early", 32'(rsp_valid), 32'd0);
        step();
        check("t1_valid", 32'(rsp_valid), 32'b0100);
        check("t1_result", 32'(rsp_result), 32'd14);
        rsp_ready = 4'b0100;
        step();
        check("t1_busy_clr", 32'(busy), 32'd0);
        check("t1_valid_clr", 32'(rsp_valid), 32'd0);

        // Requester 3 with max dividend, then wrap to requester 0
        set_op(3, 16'hFFFF, 16'd1);
        rsp_ready = 4'b1111;
        req_valid = 4'b1000;
        run_txn("wrap3", 4'b1000, 16'hFFFF);
        req_valid = 4'b1001;
        #1;
        check("wrap_to0", 32'(req_ready), 32'b0001);

        // All four requesting: 0,1,2,3,0
        set_op(0, 16'd1000, 16'd10);
        set_op(1, 16'd999, 16'd3);
        set_op(2, 16'd50000, 16'd7);
        set_op(3, 16'd12345, 16'd5);
        req_valid = 4'b1111;
        run_txn("rr0", 4'b0001, 16'd100);
        run_txn("rr1", 4'b0010, 16'd333);
        run_txn("rr2", 4'b0100, 16'd7142);
        run_txn("rr3", 4'b1000, 16'd2469);
        run_txn("rr0b", 4'b0001, 16'd100);

        // Back-pressure in RESP; non-owner ready bits must be ignored
        set_op(0, 16'd81, 16'd9);
        req_valid = 4'b0001;
        rsp_ready = '0;
        #1;
        check("bp_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1111;
        repeat (DL) step();
        for (int i = 0; i < 6; i++) begin
            rsp_ready = (i % 2 == 1) ? 4'b1110 : 4'b0000;
            #1;
            check("bp_valid", 32'(rsp_valid), 32'b0001);
            check("bp_result", 32'(rsp_result), 32'd9);
            check("bp_div_b", 32'(div_b), 32'd9);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        check("bp_still", 32'(rsp_valid), 32'b0001);
        rsp_ready = 4'b0001;
        req_valid = '0;
        step();
        check("bp_done", 32'(busy), 32'd0);
        check("bp_valid_clr", 32'(rsp_valid), 32'd0);

        // Requester 1 divides by zero
        set_op(1, 16'd5, 16'd0);
        req_valid = 4'b0010;
        rsp_ready = '0;
        #1;
        check("z_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        check("z_div_a", 32'(div_a), 32'd5);
        check("z_div_b", 32'(div_b), 32'd0);
`ifdef DIV_SHARE_ZERO_SAT_EN
        check("z_valid", 32'(rsp_valid), 32'b0010);
        check("z_result", 32'(rsp_result), 32'hFFFF);
        check("z_dbz", 32'(div_by_zero), 32'd1);
`else
        check("z_wait", 32'(rsp_valid), 32'd0);
        repeat (DL) step();
        check("z_valid", 32'(rsp_valid), 32'b0010);
        check("z_result", 32'(rsp_result), 32'hFFFF);
        check("z_dbz", 32'(div_by_zero), 32'd0);
`endif
        rsp_ready = 4'b0010;
        step();
        check("z_done", 32'(busy), 32'd0);
        check("z_dbz_clr", 32'(div_by_zero), 32'd0);

        // Reset pulsed mid-WAIT
        set_op(0, 16'd20, 16'd4);
        req_valid = 4'b0001;
        rsp_ready = '0;
        step();
        req_valid = '0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_div_a", 32'(div_a), 32'd0);
        check("mr_div_b", 32'(div_b), 32'd0);
        check("mr_result", 32'(rsp_result), 32'd0);
        check("mr_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mr_idle", 32'(busy), 32'd0);
        set_op(0, 16'd30, 16'd6);
        req_valid = 4'b0011;
        rsp_ready = 4'b1111;
        run_txn("mr_r0", 4'b0001, 16'd5);
        req_valid = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
